// File: rtl/fixed_weight_sched_if.sv
// fixed_weight_sched_if: control, random-stream and generator signals of the scheduler.
// master is the scheduler side, slave is the environment side.
interface fixed_weight_sched_if #(
    parameter int M          = 15,
    parameter int RAND_W     = 16,
    parameter int LOG_WEIGHT = 7
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  fail;
    logic [7:0]            retries;
    logic [RAND_W-1:0]     rand_data;
    logic                  rand_valid;
    logic                  rand_ready;
    logic                  gen_init_mem;
    logic                  gen_start;
    logic [M-1:0]          gen_location;
    logic [LOG_WEIGHT-1:0] gen_rd_addr;
    logic                  gen_ready;
    logic                  gen_collision;
    logic                  gen_done;
    modport master (
        input  start, rand_data, rand_valid, gen_rd_addr, gen_ready, gen_collision, gen_done,
        output busy, done, fail, retries, rand_ready, gen_init_mem, gen_start, gen_location
    );
    modport slave (
        output start, rand_data, rand_valid, gen_rd_addr, gen_ready, gen_collision, gen_done,
        input  busy, done, fail, retries, rand_ready, gen_init_mem, gen_start, gen_location
    );
endinterface

// File: rtl/fixed_weight_sched.sv
// fixed_weight_sched: rejection-samples random words into a location buffer and sequences
// the fixed-weight generator through init, location issue and collision resampling.
module fixed_weight_sched #(
    parameter int M          = 15,
    parameter int N          = 17669,
    parameter int WEIGHT     = 66,
    parameter int LOG_WEIGHT = $clog2(WEIGHT),
    parameter int RAND_W     = 16,
    parameter int MAX_RETRY  = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    fixed_weight_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, INIT, FILL, ISSUE, RESAMPLE, WAIT_DONE, DONE} state_t;
    localparam logic [M-1:0]          N_M     = M'(N);
    localparam logic [LOG_WEIGHT-1:0] K_LAST  = LOG_WEIGHT'(WEIGHT - 1);
    localparam logic [LOG_WEIGHT:0]   W_FULL  = (LOG_WEIGHT + 1)'(WEIGHT);
    localparam logic [7:0]            MAX_R   = 8'(MAX_RETRY);
    state_t                state_q, state_d;
    logic [LOG_WEIGHT-1:0] k_q, k_d;
    logic [LOG_WEIGHT:0]   n_q, n_d;
    logic                  armed_q, armed_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [7:0]            retries_q, retries_d;
    logic                  rand_ready_q, rand_ready_d;
    logic                  init_q, init_d;
    logic                  start_q, start_d;
    logic [M-1:0]          loc_q [WEIGHT];
    logic [M-1:0]          cand;
    logic                  acc;
    logic                  wr_en;
    logic [LOG_WEIGHT-1:0] wr_addr;
    assign cand = bus.rand_data[M-1:0];
    assign acc  = bus.rand_valid & rand_ready_q & (cand < N_M);
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.retries      = retries_q;
    assign bus.rand_ready   = rand_ready_q;
    assign bus.gen_init_mem = init_q;
    assign bus.gen_start    = start_q;
    assign bus.gen_location = ({1'b0, bus.gen_rd_addr} < W_FULL) ? loc_q[bus.gen_rd_addr] : '0;
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        armed_d   = armed_q;
        busy_d    = busy_q;
        fail_d    = fail_q;
        retries_d = retries_q;
        init_d    = 1'b0;
        start_d   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = k_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = INIT;
                busy_d    = 1'b1;
                fail_d    = 1'b0;
                retries_d = '0;
                k_d       = '0;
                init_d    = 1'b1;
            end
            INIT: state_d = bus.gen_ready ? FILL : INIT;
            FILL: if (acc) begin
                wr_en = 1'b1;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ISSUE;
                    n_d     = '0;
                    armed_d = 1'b1;
                end
            end
            // gen_start re-arms only after gen_ready has dropped since the last pulse
            ISSUE, WAIT_DONE: begin
                armed_d = armed_q | ~bus.gen_ready;
                if (bus.gen_done)
                    state_d = DONE;
                else if (bus.gen_ready && bus.gen_collision) begin
                    state_d = RESAMPLE;
                    n_d     = n_q - 1'b1;
                end else if (n_q == W_FULL)
                    state_d = bus.gen_ready ? ISSUE : WAIT_DONE;
                else if (bus.gen_ready && armed_q) begin
                    start_d = 1'b1;
                    armed_d = 1'b0;
                    n_d     = n_q + 1'b1;
                end
            end
            RESAMPLE: if (retries_q == MAX_R) begin
                state_d = DONE;
                fail_d  = 1'b1;
            end else if (acc) begin
                wr_en     = 1'b1;
                wr_addr   = bus.gen_rd_addr;
                retries_d = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                state_d   = ISSUE;
                armed_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        done_d       = state_d == DONE;
        rand_ready_d = (state_d == FILL) || (state_d == RESAMPLE && retries_d != MAX_R);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            n_q          <= '0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            retries_q    <= '0;
            rand_ready_q <= 1'b0;
            init_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            retries_q    <= retries_d;
            rand_ready_q <= rand_ready_d;
            init_q       <= init_d;
            start_q      <= start_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < W_FULL))
            loc_q[wr_addr] <= cand;
    end
endmodule

// File: tb/tb_fixed_weight_sched.sv
// tb_fixed_weight_sched: directed scenarios plus randomized runs against a behavioural model
// of the location buffer, retry count and completion timing, driven by a simple generator model.
module tb_fixed_weight_sched;
    localparam int M = 15, N = 17669, W = 66, LW = $clog2(W), RW = 16, MAXR = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fixed_weight_sched_if #(.M(M), .RAND_W(RW), .LOG_WEIGHT(LW)) bus ();
    fixed_weight_sched #(.M(M), .N(N), .WEIGHT(W), .LOG_WEIGHT(LW), .RAND_W(RW), .MAX_RETRY(MAXR))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0, bad = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // stimulus knobs, written only by the main sequence
    int smode = 0, inj_at = -1;
    bit vmode = 0, always_coll = 0, dup_mode = 0, both_mode = 0;
    // generator / random source state, written only by the driver
    int nconsumed = 0, nstart = 0, ninit = 0, rr_cycles = 0, widx = 0, j = 0, cd = 0;
    int cap [W];
    bit gr = 0, gc = 0, gd = 0, pend_coll = 0, injected = 0;
    logic [RW-1:0] cur = '0;
    function automatic logic [RW-1:0] word_at(int i, int md);
        if (md == 0) return RW'(i);
        if (md == 1) return (i % 2 == 0) ? 16'h7FFF : RW'(i / 2);
        return ($urandom_range(0, 3) == 0) ? RW'($urandom_range(N, 65535)) : RW'($urandom_range(0, 1999));
    endfunction
    initial begin
        bit s_start, s_init, s_hs, dup;
        int s_loc;
        bus.rand_valid = 1'b0; bus.rand_data = '0; bus.gen_ready = 1'b0;
        bus.gen_collision = 1'b0; bus.gen_done = 1'b0; bus.gen_rd_addr = '0;
        forever begin
            @(posedge clk);
            s_start = bus.gen_start; s_init = bus.gen_init_mem;
            s_hs = bus.rand_valid && bus.rand_ready; s_loc = int'(bus.gen_location);
            gc = 1'b0; gd = 1'b0;
            if (!rst_n) begin
                gr = 1'b0; j = 0; cd = 0; pend_coll = 0;
            end else begin
                if (bus.rand_ready) rr_cycles++;
                if (s_hs) begin nconsumed++; widx++; cur = word_at(widx, smode); end
                if (s_init) begin
                    ninit++; j = 0; cd = 3; gr = 1'b0; pend_coll = 0; injected = 0;
                    widx = 0; cur = word_at(0, smode);
                end else if (s_start) begin
                    nstart++; gr = 1'b0; cd = $urandom_range(1, 3);
                    dup = 0;
                    for (int i = 0; i < j; i++) if (cap[i] == s_loc) dup = 1;
                    pend_coll = always_coll || (inj_at == j && !injected) || (dup_mode && dup);
                    if (inj_at == j) injected = 1;
                    cap[j] = s_loc;
                    if (!pend_coll) j++;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        gr = 1'b1;
                        if (j == W) begin gd = 1'b1; gc = both_mode; end
                        else begin gc = pend_coll; pend_coll = 0; end
                    end
                end
            end
            #1;
            bus.rand_data = cur;
            bus.rand_valid = vmode ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.gen_ready = gr; bus.gen_collision = gc; bus.gen_done = gd;
            bus.gen_rd_addr = LW'(j);
        end
    end
    // behavioural model: what the outputs must be, from handshakes and generator events
    bit mbusy = 0, mdone = 0, mfail = 0, mpend = 0, mfailpend = 0, minit = 0;
    int mret = 0, macc = 0;
    int exp_loc [W];
    always @(posedge clk or negedge rst_n) begin
        int c, ra;
        if (!rst_n) begin
            mbusy = 0; mdone = 0; mfail = 0; mpend = 0; mfailpend = 0; minit = 0; mret = 0; macc = 0;
        end else begin
            minit = 0;
            if (mdone) begin
                mdone = 0; mbusy = 0;
            end else if (!mbusy) begin
                if (bus.start) begin mbusy = 1; mret = 0; mfail = 0; macc = 0; mpend = 0; minit = 1; end
            end else begin
                if (bus.rand_valid && bus.rand_ready) begin
                    c = int'(bus.rand_data[M-1:0]);
                    ra = int'(bus.gen_rd_addr);
                    if (c < N) begin
                        if (mpend) begin
                            if (ra < W) exp_loc[ra] = c;
                            mpend = 0;
                            mret = (mret == 255) ? 255 : mret + 1;
                        end else if (macc < W) begin
                            exp_loc[macc] = c; macc++;
                        end
                    end
                end
                if (mfailpend) begin mdone = 1; mfail = 1; mfailpend = 0; end
                else if (bus.gen_done) mdone = 1;
                else if (bus.gen_ready && bus.gen_collision) begin
                    if (mret == MAXR) mfailpend = 1; else mpend = 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        int ra;
        if (rst_n) begin
            ra = int'(bus.gen_rd_addr);
            chk("busy", bus.busy, mbusy);
            chk("done", bus.done, mdone);
            chk("fail", bus.fail, mfail);
            chk("retries", bus.retries, mret);
            chk("init_pulse", bus.gen_init_mem, minit);
            chk("rr_allowed", bus.rand_ready && !(mbusy && !mdone && (macc < W || (mpend && mret < MAXR))), 0);
            if (mpend) chk("rr_resample", bus.rand_ready, 1);
            chk("start_ok", bus.gen_start && !(mbusy && !mdone && macc == W && !mpend), 0);
            if (ra >= W) chk("loc_oob", bus.gen_location, 0);
            else if (ra < macc) chk("loc", bus.gen_location, exp_loc[ra]);
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic run(input bit hold);
        int cyc = 0;
        @(negedge clk); bus.start = 1'b1;
        if (!hold) begin @(negedge clk); bus.start = 1'b0; end
        while (!bus.done && cyc < 5000) begin @(negedge clk); cyc++; end
        bus.start = 1'b0;
        chk("done_seen", bus.done, 1);
    endtask
    function automatic int loc_idx_errs();
        int e = 0;
        for (int i = 0; i < W; i++) if (cap[i] != i) e++;
        return e;
    endfunction
    initial begin
        int c0, s0, r0, i0, e, cyc;
        bus.start = 1'b0;
        tick(3);
        chk("rst_outs", {bus.busy, bus.done, bus.fail, bus.retries, bus.rand_ready, bus.gen_init_mem, bus.gen_start}, 0);
        #3 rst_n = 1'b1;
        tick(2);
        // sequential stream, no collisions
        c0 = nconsumed; s0 = nstart; r0 = rr_cycles;
        run(0);
        chk("t1_fail", bus.fail, 0);
        chk("t1_retries", bus.retries, 0);
        chk("t1_starts", nstart - s0, 66);
        chk("t1_words", nconsumed - c0, 66);
        chk("t1_fill_cycles", rr_cycles - r0, 66);
        chk("t1_loc_eq_idx", loc_idx_errs(), 0);
        chk("t1_model_loc65", exp_loc[65], 65);
        tick(1);
        chk("t1_busy_after", bus.busy, 0);
        // every other word rejected
        smode = 1; c0 = nconsumed;
        run(0);
        chk("t2_words", nconsumed - c0, 132);
        chk("t2_loc_eq_idx", loc_idx_errs(), 0);
        e = 0;
        for (int i = 0; i < W; i++) if (cap[i] == 32767) e++;
        chk("t2_rejects_absent", e, 0);
        tick(2);
        // one collision at index 10
        smode = 0; inj_at = 10; c0 = nconsumed; s0 = nstart;
        run(0);
        chk("t3_retries", bus.retries, 1);
        chk("t3_words", nconsumed - c0, 67);
        chk("t3_starts", nstart - s0, 67);
        chk("t3_loc10", cap[10], 66);
        chk("t3_model_loc10", exp_loc[10], 66);
        inj_at = -1;
        tick(2);
        // retry limit exhausted
        always_coll = 1; c0 = nconsumed; s0 = nstart;
        run(0);
        chk("t4_fail", bus.fail, 1);
        chk("t4_retries", bus.retries, 3);
        chk("t4_starts", nstart - s0, 4);
        chk("t4_words", nconsumed - c0, 69);
        tick(1);
        chk("t4_busy_after", bus.busy, 0);
        chk("t4_fail_held", bus.fail, 1);
        always_coll = 0;
        tick(2);
        // reset in the middle of the fill
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (macc < 30 && cyc < 500) begin @(negedge clk); cyc++; end
        chk("t5_reached30", macc, 30);
        #3 rst_n = 1'b0;
        #1 chk("t5_rst_outs", {bus.busy, bus.done, bus.fail, bus.retries, bus.rand_ready, bus.gen_init_mem, bus.gen_start}, 0);
        tick(2);
        #3 rst_n = 1'b1;
        tick(1);
        c0 = nconsumed;
        run(0);
        chk("t5_fail", bus.fail, 0);
        chk("t5_words", nconsumed - c0, 66);
        chk("t5_loc_eq_idx", loc_idx_errs(), 0);
        tick(2);
        // start held for the whole run, gen_done together with gen_collision
        both_mode = 1; i0 = ninit;
        run(1);
        chk("t6_inits", ninit - i0, 1);
        chk("t6_retries", bus.retries, 0);
        chk("t6_fail", bus.fail, 0);
        tick(4);
        chk("t6_busy_after", bus.busy, 0);
        chk("t6_inits_after", ninit - i0, 1);
        both_mode = 0;
        // randomized words, valid gaps and duplicate-driven collisions
        smode = 2; vmode = 1; dup_mode = 1;
        for (int r = 0; r < 10; r++) begin
            run(0);
            tick($urandom_range(1, 4));
        end
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
